sim_monitor: RTL and testbench

//  Synthesizable end-of-test and trace monitor bound beside the datapath. Watches the data-memory

---
 rtl/sim_monitor_pkg.sv | 25 ++
 rtl/sim_trace_fifo.sv | 91 +++++++++
 rtl/sim_monitor.sv | 149 ++++++++++++++
 tb/tb_sim_monitor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_monitor_pkg.sv
// sim_monitor_pkg
//  Shared types and constants for the end-of-test / trace monitor.
//  - state_t       : encoded monitor state, visible on o_state
//  - trace_entry_t : one trace record {register index, write data}
//  - TOHOST_PASS   : TOHOST value that signals a passing test
package sim_monitor_pkg;

    localparam int PKG_XLEN = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PASS    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    typedef struct packed {
        logic [4:0]          wnum;
        logic [PKG_XLEN-1:0] wd;
    } trace_entry_t;

    localparam logic [31:0] TOHOST_PASS = 32'd1;

endpackage

// File: rtl/sim_trace_fifo.sv
// sim_trace_fifo
//  First-word-fall-through FIFO for register-file trace records.
//  Ports:
//    i_clk, i_rst        clock, asynchronous active-high reset
//    i_flush             empties the FIFO and clears the overflow flag
//    i_push, i_push_data write request and data
//    i_pop               pop the head (ignored when empty)
//    o_valid, o_head     FIFO non-empty, head entry (0 when empty)
//    o_full              all DEPTH entries occupied
//    o_overflow          sticky: a push was dropped because the FIFO was full
module sim_trace_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             empty, full, do_push, do_pop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == (AW+1)'(DEPTH));
        // A pop in the same cycle frees a slot, so a push into a full FIFO
        // still lands; a pop on an empty FIFO is simply ignored.
        do_pop  = i_pop && !empty;
        do_push = i_push && (!full || do_pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (i_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (i_push && !do_push) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_push_data;
    end

    assign o_valid    = !empty;
    assign o_head     = empty ? '0 : mem_q[rd_ptr_q];
    assign o_full     = full;
    assign o_overflow = overflow_q;

endmodule

// File: rtl/sim_monitor.sv
// sim_monitor
//  End-of-test and trace monitor placed beside the datapath. Detects TOHOST
//  writes (riscv-tests convention), runs a cycle watchdog, and records
//  register-file writes into a FWFT trace FIFO.
//  Ports:
//    i_clk, i_rst                  clock, asynchronous active-high reset
//    i_start                       arm/re-arm from IDLE or a terminal state
//    i_dm_wen/addr/wdata           data-memory write port (TOHOST detection)
//    i_rf_wen/wnum/wd              register-file write port (trace source)
//    i_trace_ren                   pop trace head
//    o_trace_valid/data/overflow   trace FIFO head and sticky drop flag
//    o_state                       encoded monitor state
//    o_done, o_pass, o_fail_code   test verdict
//    o_cycle_count                 RUN cycles elapsed (saturating)
//    o_rf_write_count              qualifying rf writes in RUN (saturating)
module sim_monitor
    import sim_monitor_pkg::*;
#(
    parameter int                XLEN           = 32,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h1000,
    parameter int                TIMEOUT_CYCLES = 100000,
    parameter int                TRACE_DEPTH    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_dm_wen,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [XLEN-1:0]   i_dm_wdata,
    input  logic              i_rf_wen,
    input  logic [4:0]        i_rf_wnum,
    input  logic [XLEN-1:0]   i_rf_wd,
    input  logic              i_trace_ren,
    output logic              o_trace_valid,
    output logic [XLEN+4:0]   o_trace_data,
    output logic              o_trace_overflow,
    output logic [2:0]        o_state,
    output logic              o_done,
    output logic              o_pass,
    output logic [XLEN-1:0]   o_fail_code,
    output logic [31:0]       o_cycle_count,
    output logic [31:0]       o_rf_write_count
);

    state_t            state_q, state_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic [31:0]       rf_write_count_q, rf_write_count_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [XLEN-1:0]   fail_code_q, fail_code_d;

    logic              in_run;
    logic              arm;
    logic              tohost_hit;
    logic              trace_push;
    logic              trace_full;

    assign in_run     = (state_q == RUN);
    // i_start is ignored while a test is running.
    assign arm        = i_start && !in_run;
    assign tohost_hit = in_run && i_dm_wen && (i_dm_addr == TOHOST_ADDR);
    assign trace_push = in_run && i_rf_wen && (i_rf_wnum != 5'd0);

    always_comb begin
        state_d          = state_q;
        cycle_count_d    = cycle_count_q;
        rf_write_count_d = rf_write_count_q;
        done_d           = done_q;
        pass_d           = pass_q;
        fail_code_d      = fail_code_q;

        if (arm) begin
            state_d          = RUN;
            cycle_count_d    = '0;
            rf_write_count_d = '0;
            done_d           = 1'b0;
            pass_d           = 1'b0;
            fail_code_d      = '0;
        end else if (in_run) begin
            // The exit cycle is itself a RUN cycle and is counted.
            if (cycle_count_q != 32'hFFFF_FFFF) cycle_count_d = cycle_count_q + 32'd1;
            // Dropped trace entries still count as observed writes.
            if (trace_push && rf_write_count_q != 32'hFFFF_FFFF)
                rf_write_count_d = rf_write_count_q + 32'd1;

            // TOHOST exits take priority over the watchdog in the same cycle;
            // even TOHOST values are not exits.
            if (tohost_hit && i_dm_wdata == XLEN'(TOHOST_PASS)) begin
                state_d = PASS;
                done_d  = 1'b1;
                pass_d  = 1'b1;
            end else if (tohost_hit && i_dm_wdata[0]) begin
                state_d     = FAIL;
                done_d      = 1'b1;
                fail_code_d = i_dm_wdata >> 1;
            end else if (cycle_count_q == 32'(TIMEOUT_CYCLES - 1)) begin
                state_d = TIMEOUT;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q          <= IDLE;
            cycle_count_q    <= '0;
            rf_write_count_q <= '0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            fail_code_q      <= '0;
        end else begin
            state_q          <= state_d;
            cycle_count_q    <= cycle_count_d;
            rf_write_count_q <= rf_write_count_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            fail_code_q      <= fail_code_d;
        end
    end

    sim_trace_fifo #(
        .WIDTH (XLEN + 5),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (arm),
        .i_push      (trace_push),
        .i_push_data ({i_rf_wnum, i_rf_wd}),
        .i_pop       (i_trace_ren),
        .o_valid     (o_trace_valid),
        .o_head      (o_trace_data),
        .o_full      (trace_full),
        .o_overflow  (o_trace_overflow)
    );

    assign o_state          = state_q;
    assign o_done           = done_q;
    assign o_pass           = pass_q;
    assign o_fail_code      = fail_code_q;
    assign o_cycle_count    = cycle_count_q;
    assign o_rf_write_count = rf_write_count_q;

    // Full status is only needed inside the FIFO; keep it observable for debug.
    logic unused_full;
    assign unused_full = trace_full;

endmodule

// File: tb/tb_sim_monitor.sv
module tb_sim_monitor;
    import sim_monitor_pkg::*;

    localparam int          TO    = 20;
    localparam int          DEPTH = 4;
    localparam logic [31:0] TH    = 32'h1000;

    logic        clk;
    logic        i_rst, i_start, i_dm_wen, i_rf_wen, i_trace_ren;
    logic [31:0] i_dm_addr, i_dm_wdata, i_rf_wd;
    logic [4:0]  i_rf_wnum;
    logic        o_trace_valid, o_trace_overflow, o_done, o_pass;
    logic [36:0] o_trace_data;
    logic [2:0]  o_state;
    logic [31:0] o_fail_code, o_cycle_count, o_rf_write_count;

    sim_monitor #(
        .XLEN(32), .ADDR_W(32), .TOHOST_ADDR(TH),
        .TIMEOUT_CYCLES(TO), .TRACE_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_dm_wen(i_dm_wen), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
        .i_rf_wen(i_rf_wen), .i_rf_wnum(i_rf_wnum), .i_rf_wd(i_rf_wd),
        .i_trace_ren(i_trace_ren),
        .o_trace_valid(o_trace_valid), .o_trace_data(o_trace_data),
        .o_trace_overflow(o_trace_overflow), .o_state(o_state),
        .o_done(o_done), .o_pass(o_pass), .o_fail_code(o_fail_code),
        .o_cycle_count(o_cycle_count), .o_rf_write_count(o_rf_write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    string phase = "reset";

    // Reference model: verdict, counters and a queue of trace entries.
    int           m_state;   // 0 idle, 1 run, 2 pass, 3 fail, 4 timeout
    logic [31:0]  m_cycles, m_rfc, m_fail;
    logic         m_ovf;
    trace_entry_t m_q[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s:%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cycles = 0; m_rfc = 0; m_fail = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        trace_entry_t e;
        bit run;
        bit exited;
        run = (m_state == 1);
        if (i_start && !run) begin
            model_reset();
            m_state = 1;
            return;
        end
        if (i_trace_ren && m_q.size() > 0) void'(m_q.pop_front());
        if (!run) return;
        if (i_rf_wen && i_rf_wnum != 0) begin
            if (m_rfc != 32'hFFFF_FFFF) m_rfc++;
            e.wnum = i_rf_wnum;
            e.wd   = i_rf_wd;
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else m_ovf = 1'b1;
        end
        exited = 0;
        if (i_dm_wen && i_dm_addr == TH) begin
            if (i_dm_wdata == 32'd1) begin
                m_state = 2; exited = 1;
            end else if (i_dm_wdata[0]) begin
                m_state = 3; m_fail = i_dm_wdata >> 1; exited = 1;
            end
        end
        if (!exited && m_cycles == 32'(TO - 1)) m_state = 4;
        if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
    endtask

    task automatic check_all();
        logic [36:0] exp_d;
        exp_d = (m_q.size() > 0) ? m_q[0] : 37'd0;
        chk("state", o_state, m_state);
        chk("done", o_done, m_state >= 2);
        chk("pass", o_pass, m_state == 2);
        chk("fail_code", o_fail_code, m_fail);
        chk("cycles", o_cycle_count, m_cycles);
        chk("rf_writes", o_rf_write_count, m_rfc);
        chk("valid", o_trace_valid, m_q.size() > 0);
        chk("data", o_trace_data, exp_d);
        chk("overflow", o_trace_overflow, m_ovf);
        $display("[%0t] %s st=%0d cyc=%0d rfw=%0d q=%0d ovf=%0d", $time, phase,
                 o_state, o_cycle_count, o_rf_write_count, m_q.size(), o_trace_overflow);
    endtask

    task automatic idle_inputs();
        i_start = 0; i_dm_wen = 0; i_dm_addr = 0; i_dm_wdata = 0;
        i_rf_wen = 0; i_rf_wnum = 0; i_rf_wd = 0; i_trace_ren = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        idle_inputs();
    endtask

    task automatic rf(input logic [4:0] n, input logic [31:0] d);
        i_rf_wen = 1; i_rf_wnum = n; i_rf_wd = d;
    endtask

    task automatic tohost(input logic [31:0] d);
        i_dm_wen = 1; i_dm_addr = TH; i_dm_wdata = d;
    endtask

    task automatic start();
        i_start = 1;
        tick();
    endtask

    initial begin
        idle_inputs();
        i_rst = 1;
        model_reset();
        @(posedge clk); #1;
        check_all();
        @(posedge clk); #1;
        i_rst = 0;

        // 1: pass with one trace entry; x0 write not traced
        phase = "t1";
        start();
        rf(5'd5, 32'hA); tick();
        rf(5'd0, 32'h7); tick();
        for (int i = 2; i < 10; i++) tick();
        tohost(32'd1); tick();
        chk("t1_state", o_state, 3'd2);
        chk("t1_pass", o_pass, 1'b1);
        chk("t1_cycles", o_cycle_count, 32'd11);
        chk("t1_rfw", o_rf_write_count, 32'd1);
        chk("t1_head", o_trace_data, {5'd5, 32'hA});
        tick(); tick();
        chk("t1_frozen", o_cycle_count, 32'd11);

        // 2: even TOHOST ignored, then failing code
        phase = "t2";
        start();
        tohost(32'h4); rf(5'd1, 32'h11); tick();
        chk("t2_even_ignored", o_state, 3'd1);
        rf(5'd2, 32'h22); i_trace_ren = 1; tick();
        i_dm_wen = 1; i_dm_addr = TH + 32'd4; i_dm_wdata = 32'd1; tick();
        chk("t2_near_addr", o_state, 3'd1);
        tohost(32'h7); tick();
        chk("t2_fail_code", o_fail_code, 32'd3);
        chk("t2_pass", o_pass, 1'b0);
        chk("t2_done", o_done, 1'b1);

        // 3: watchdog, then TOHOST in the timeout cycle wins
        phase = "t3";
        start();
        for (int i = 0; i < TO - 1; i++) tick();
        chk("t3_still_run", o_state, 3'd1);
        tick();
        chk("t3_timeout", o_state, 3'd4);
        chk("t3_cycles", o_cycle_count, 32'(TO));
        start();
        for (int i = 0; i < TO - 1; i++) tick();
        tohost(32'd1); tick();
        chk("t3_pass_wins", o_state, 3'd2);
        chk("t3_pass_cycles", o_cycle_count, 32'(TO));

        // 4: overflow, then pop+push at full
        phase = "t4";
        start();
        for (int i = 0; i < 6; i++) begin
            rf(5'(i + 1), 32'h100 + 32'(i)); tick();
        end
        chk("t4_ovf", o_trace_overflow, 1'b1);
        chk("t4_rfw", o_rf_write_count, 32'd6);
        rf(5'd7, 32'h77); i_trace_ren = 1; tick();
        chk("t4_head_after_pp", o_trace_data, {5'd2, 32'h101});
        for (int i = 0; i < 4; i++) begin
            chk("t4_valid_before_pop", o_trace_valid, 1'b1);
            i_trace_ren = 1; tick();
        end
        chk("t4_drained", o_trace_valid, 1'b0);
        tohost(32'd1); tick();

        // 5: restart from PASS clears, empty push+pop, async reset
        phase = "t5";
        start();
        chk("t5_ovf_clr", o_trace_overflow, 1'b0);
        chk("t5_cyc_clr", o_cycle_count, 32'd0);
        chk("t5_run", o_state, 3'd1);
        rf(5'd3, 32'h33); i_trace_ren = 1; tick();
        chk("t5_empty_pushpop", o_trace_data, {5'd3, 32'h33});
        rf(5'd4, 32'h44); tick();
        #2;
        i_rst = 1;
        #1;
        model_reset();
        check_all();
        chk("t5_async_state", o_state, 3'd0);
        chk("t5_async_valid", o_trace_valid, 1'b0);
        @(posedge clk); #1;
        check_all();
        i_rst = 0;

        // 6: randomized traffic against the model
        phase = "rand";
        for (int n = 0; n < 300; n++) begin
            i_start = ($urandom_range(0, 15) == 0);
            i_rf_wen = $urandom_range(0, 1);
            i_rf_wnum = 5'($urandom_range(0, 31));
            i_rf_wd = $urandom;
            i_trace_ren = ($urandom_range(0, 2) == 0);
            i_dm_wen = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0, 1:    i_dm_addr = TH;
                2:       i_dm_addr = TH + 32'd1;
                default: i_dm_addr = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       i_dm_wdata = 32'd1;
                1:       i_dm_wdata = 32'd0;
                2:       i_dm_wdata = 32'd2;
                3:       i_dm_wdata = 32'd7;
                default: i_dm_wdata = $urandom;
            endcase
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
